// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle between the UART pin and its consumer (Uart2wb).
// master = line driver plus byte consumer, slave = the uart_rx receiver.
interface uart_rx_if;
    logic       in_RxBit;
    logic [7:0] out_DataByte;
    logic       out_RxDone;
    logic       out_FrameErr;
    logic       out_ParityErr;
    logic       out_Busy;

    modport master (
        output in_RxBit,
        input  out_DataByte, out_RxDone, out_FrameErr, out_ParityErr, out_Busy
    );
    modport slave (
        input  in_RxBit,
        output out_DataByte, out_RxDone, out_FrameErr, out_ParityErr, out_Busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, mid-bit sampling by cycle count.
// Optional parity bit after bit 7 when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_ODD   = 0
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
        $error("uart_rx: CLKS_PER_BIT must be >= 4 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync_q;
    logic          rxs;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shreg, sh_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          done_q, done_nxt;
    logic          fe_q, fe_nxt;
    logic          par_ok;

    // Sync flops reset to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.in_RxBit};
    end
    assign rxs = sync_q[1];

`ifdef UART_RX_PARITY_EN
    logic par_q, par_nxt, pe_q, pe_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
            pe_q  <= 1'b0;
        end else begin
            par_q <= par_nxt;
            pe_q  <= pe_nxt;
        end
    end
    assign par_ok            = ((^shreg) ^ par_q) == 1'(PARITY_ODD);
    assign bus.out_ParityErr = pe_q;
`else
    assign par_ok            = 1'b1;
    assign bus.out_ParityErr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= sh_nxt;
            data_q  <= data_nxt;
            done_q  <= done_nxt;
            fe_q    <= fe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        data_nxt  = data_q;
        done_nxt  = 1'b0;
        fe_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_q;
        pe_nxt    = 1'b0;
`endif
        case (state)
            WAIT_IDLE: if (rxs) state_nxt = IDLE;
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt   = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rxs, shreg[7:1]};
                    bit_nxt = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_nxt = PARITY;
`else
                    if (bit_idx == 3'd7) state_nxt = STOP;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt   = '0;
                    par_nxt   = rxs;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                    pe_nxt  = !par_ok;
`endif
                    // Low stop may be a break: wait for the line to return high.
                    if (!rxs) begin
                        fe_nxt    = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end else begin
                        state_nxt = IDLE;
                        if (par_ok) begin
                            data_nxt = shreg;
                            done_nxt = 1'b1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    assign bus.out_DataByte = data_q;
    assign bus.out_RxDone   = done_q;
    assign bus.out_FrameErr = fe_q;
    assign bus.out_Busy     = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a timing/byte model derived from the frame format.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx;
    localparam int CPB  = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB   = 11;
`else
    localparam int NB   = 10;
`endif
    // Pin edge to pulse: 2 sync + half bit + (NB-1) bits + output register.
    localparam int LAT  = 2 + CPB/2 + (NB-1)*CPB + 1;

    typedef struct {
        int unsigned t;
        logic [7:0]  b;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t         done_q[$];
    int unsigned fe_q[$];
    int unsigned pe_q[$];
    int          overlap = 0;
    int          n_pass = 0;
    int          n_fail = 0;
`ifdef UART_RX_PARITY_EN
    logic        flip_par = 1'b0;
`endif

    always @(negedge clk) begin
        if (bus.out_RxDone)    done_q.push_back('{cyc, bus.out_DataByte});
        if (bus.out_FrameErr)  fe_q.push_back(cyc);
        if (bus.out_ParityErr) pe_q.push_back(cyc);
        if (bus.out_RxDone && (bus.out_FrameErr || bus.out_ParityErr)) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        done_q.delete();
        fe_q.delete();
        pe_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int unsigned t0);
        t0 = cyc;
        bus.in_RxBit = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.in_RxBit = d[i];
            wait_cyc(CPB);
        end
`ifdef UART_RX_PARITY_EN
        bus.in_RxBit = (^d) ^ flip_par;
        wait_cyc(CPB);
`endif
        bus.in_RxBit = stop;
        wait_cyc(CPB);
    endtask

    task automatic expect_done(input string tag, input logic [7:0] b, input int unsigned t0);
        ev_t e;
        chk({tag, "_cnt"}, done_q.size(), 1);
        chk({tag, "_fe"}, fe_q.size(), 0);
        if (done_q.size() > 0) begin
            e = done_q.pop_front();
            chk({tag, "_byte"}, e.b, b);
            chk({tag, "_lat"}, e.t - t0, LAT);
        end
        chk({tag, "_hold"}, bus.out_DataByte, b);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_byte"}, bus.out_DataByte, 8'h00);
        chk({tag, "_done"}, bus.out_RxDone, 1'b0);
        chk({tag, "_fe"}, bus.out_FrameErr, 1'b0);
        chk({tag, "_pe"}, bus.out_ParityErr, 1'b0);
        chk({tag, "_busy"}, bus.out_Busy, 1'b1);
    endtask

    initial begin
        int unsigned t0, t1;
        logic [7:0]  b, last_good;
        logic        stop;
        ev_t         exp_done[$];
        int unsigned exp_fe[$];
        int unsigned exp_pe[$];
        ev_t         e;

        bus.in_RxBit = 1'b1;
        wait_cyc(3);
        chk_reset("rst0");
        rst = 1'b0;
        wait_cyc(3);
        chk("idle_busy", bus.out_Busy, 1'b0);

        // Plain good frame
        send_frame(8'hA5, 1'b1, t0);
        expect_done("a5", 8'hA5, t0);

        // Short low glitch must be rejected at mid-start
        clear_q();
        bus.in_RxBit = 1'b0;
        wait_cyc(4);
        bus.in_RxBit = 1'b1;
        wait_cyc(8);
        chk("glitch_busy", bus.out_Busy, 1'b0);
        wait_cyc(2*CPB);
        chk("glitch_done", done_q.size(), 0);
        chk("glitch_fe", fe_q.size(), 0);

        // Low stop bit, line held low (break), then recover
        send_frame(8'h3C, 1'b0, t0);
        wait_cyc(40);
        chk("ferr_cnt", fe_q.size(), 1);
        if (fe_q.size() > 0) chk("ferr_lat", fe_q.pop_front() - t0, LAT);
        chk("ferr_done", done_q.size(), 0);
        chk("ferr_hold", bus.out_DataByte, 8'hA5);
        bus.in_RxBit = 1'b1;
        wait_cyc(CPB);
        send_frame(8'h00, 1'b1, t0);
        expect_done("z00", 8'h00, t0);

        // Back-to-back frames, zero idle gap
        send_frame(8'h55, 1'b1, t0);
        send_frame(8'hAA, 1'b1, t1);
        chk("b2b_cnt", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("b2b_b0", done_q[0].b, 8'h55);
            chk("b2b_b1", done_q[1].b, 8'hAA);
            chk("b2b_gap", done_q[1].t - done_q[0].t, NB*CPB);
            chk("b2b_lat", done_q[0].t - t0, LAT);
        end
        clear_q();

        // Reset during data bit 3; remaining bits are high so no false start follows
        b = {5'b11111, 3'($urandom)};
        fork
            send_frame(b, 1'b1, t0);
            begin
                wait_cyc(4*CPB + 6);
                rst = 1'b1;
                wait_cyc(2);
                chk_reset("rst_mid");
                rst = 1'b0;
            end
        join
        wait_cyc(2*CPB);
        chk("rst_mid_done", done_q.size(), 0);
        chk("rst_mid_fe", fe_q.size(), 0);
        send_frame(8'h81, 1'b1, t0);
        expect_done("x81", 8'h81, t0);

`ifdef UART_RX_PARITY_EN
        flip_par = 1'b0;
        send_frame(8'h07, 1'b1, t0);
        expect_done("par_ok", 8'h07, t0);
        chk("par_ok_pe", pe_q.size(), 0);
        flip_par = 1'b1;
        send_frame(8'h07, 1'b1, t0);
        flip_par = 1'b0;
        chk("par_bad_pe", pe_q.size(), 1);
        if (pe_q.size() > 0) chk("par_bad_lat", pe_q.pop_front() - t0, LAT);
        chk("par_bad_done", done_q.size(), 0);
        chk("par_bad_hold", bus.out_DataByte, 8'h07);
        clear_q();
        last_good = 8'h07;
`else
        last_good = 8'h81;
`endif

        // Random frames: random data, occasional bad stop, random gaps
        clear_q();
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            flip_par = ($urandom_range(0, 5) == 0);
            if (flip_par) exp_pe.push_back(0);
`endif
            send_frame(b, stop, t0);
`ifdef UART_RX_PARITY_EN
            if (flip_par) exp_pe[exp_pe.size()-1] = t0 + LAT;
            if (stop && !flip_par) begin
`else
            if (stop) begin
`endif
                exp_done.push_back('{t0 + LAT, b});
                last_good = b;
            end
            if (!stop) begin
                exp_fe.push_back(t0 + LAT);
                bus.in_RxBit = 1'b1;
                wait_cyc(CPB + $urandom_range(0, CPB));
            end else if ($urandom_range(0, 2) != 0) begin
                wait_cyc($urandom_range(1, 3*CPB));
            end
        end
        bus.in_RxBit = 1'b1;
        wait_cyc(2*CPB);

        chk("rnd_done_cnt", done_q.size(), exp_done.size());
        while (done_q.size() > 0 && exp_done.size() > 0) begin
            e = done_q.pop_front();
            chk("rnd_done_t", e.t, exp_done[0].t);
            chk("rnd_done_b", e.b, exp_done[0].b);
            void'(exp_done.pop_front());
        end
        chk("rnd_fe_cnt", fe_q.size(), exp_fe.size());
        while (fe_q.size() > 0 && exp_fe.size() > 0)
            chk("rnd_fe_t", fe_q.pop_front(), exp_fe.pop_front());
        chk("rnd_pe_cnt", pe_q.size(), exp_pe.size());
        while (pe_q.size() > 0 && exp_pe.size() > 0)
            chk("rnd_pe_t", pe_q.pop_front(), exp_pe.pop_front());
        chk("rnd_hold", bus.out_DataByte, last_good);
        chk("end_busy", bus.out_Busy, 1'b0);
        chk("no_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
